// File: rtl/adc_sample_store_mc.sv
// ADC sample store: captures {channel,data} response samples into a slot RAM with
// sequence/ring capture modes, sticky status flags and a maskable level interrupt.
module adc_sample_store_mc #(
  parameter int NUM_SLOTS = 64,
  parameter int DATA_W    = 12,
  parameter int CH_W      = 5,
  localparam int AW       = $clog2(NUM_SLOTS) + 1
) (
  input  logic              clock_clk,
  input  logic              reset_sink_reset,
  input  logic              response_valid,
  input  logic [CH_W-1:0]   response_channel,
  input  logic [DATA_W-1:0] response_data,
  input  logic              response_endofpacket,
  input  logic [AW-1:0]     sample_store_csr_address,
  input  logic              sample_store_csr_read,
  input  logic              sample_store_csr_write,
  input  logic [31:0]       sample_store_csr_writedata,
  output logic [31:0]       sample_store_csr_readdata,
  output logic              sample_store_irq_irq
);

  localparam int PW = $clog2(NUM_SLOTS);
  localparam int WW = CH_W + DATA_W;
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_SLOTS - 1);
  localparam logic [PW-1:0] HALF_IDX = PW'(NUM_SLOTS / 2 - 1);
  localparam logic [AW-1:0] CTRL_ADDR = AW'(NUM_SLOTS);
  localparam logic [AW-1:0] STAT_ADDR = AW'(NUM_SLOTS + 1);

  logic                 rst;
  logic [PW-1:0]        wptr_q, wptr_n;
  logic                 drop_q, drop_n;
  logic [3:0]           ie_q;
  logic                 mode_q;
  logic [3:0]           status_q;
  logic [3:0]           flag_set;
  logic [3:0]           flag_w1c;
  logic [NUM_SLOTS-1:0] slot_vld_q;
  logic                 irq_q;
  logic                 we;

  logic [WW-1:0]        mem [NUM_SLOTS];
  logic [WW-1:0]        ram_rd_p1;
  logic                 rd_slot_p1;
  logic                 rd_vld_p1;
  logic [31:0]          rd_reg_p1;

  logic                 is_slot, is_ctrl, is_stat;
  logic                 ctrl_wr, stat_wr, clear_now;
  logic [PW-1:0]        rd_idx;
  logic [31:0]          ctrl_word, stat_word;
  logic                 unused_wd;

  assign rst       = reset_sink_reset;
  assign is_slot   = ~sample_store_csr_address[AW-1];
  assign is_ctrl   = (sample_store_csr_address == CTRL_ADDR);
  assign is_stat   = (sample_store_csr_address == STAT_ADDR);
  assign ctrl_wr   = sample_store_csr_write & is_ctrl;
  assign stat_wr   = sample_store_csr_write & is_stat;
  assign clear_now = ctrl_wr & sample_store_csr_writedata[9];
  assign flag_w1c  = stat_wr ? sample_store_csr_writedata[3:0] : 4'b0;
  assign rd_idx    = sample_store_csr_address[PW-1:0];
  assign unused_wd = ^{sample_store_csr_writedata[31:10], sample_store_csr_writedata[7:4]};

  assign ctrl_word = {23'b0, mode_q, 4'b0, ie_q};
  assign stat_word = {16'(wptr_q), 12'b0, status_q};

  // Capture control: write enable, next write pointer, drop state and flag-set events
  always_comb begin
    we       = 1'b0;
    wptr_n   = wptr_q;
    drop_n   = drop_q & ~mode_q;
    flag_set = 4'b0;
    if (clear_now) begin
      wptr_n = '0;
      drop_n = 1'b0;
    end else if (response_valid) begin
      if (!mode_q) begin
        we = ~drop_q;
        if (response_endofpacket) begin
          flag_set[0] = 1'b1;
          wptr_n      = '0;
          drop_n      = 1'b0;
        end else if (!drop_q) begin
          // Last slot filled mid-pass: hold the pointer and drop the rest of the pass.
          if (wptr_q == LAST_IDX) begin
            flag_set[2] = 1'b1;
            drop_n      = 1'b1;
          end else begin
            wptr_n = wptr_q + 1'b1;
          end
        end
      end else begin
        we          = 1'b1;
        wptr_n      = wptr_q + 1'b1;
        flag_set[0] = response_endofpacket;
        flag_set[1] = (wptr_q == HALF_IDX);
        if (wptr_q == LAST_IDX) begin
          flag_set[2] = 1'b1;
          flag_set[3] = status_q[2];
        end
      end
    end
  end

  // Stage p0: control state, flags, slot valid bits, interrupt
  always_ff @(posedge clock_clk) begin
    if (rst) begin
      wptr_q     <= '0;
      drop_q     <= 1'b0;
      ie_q       <= 4'b0;
      mode_q     <= 1'b0;
      status_q   <= 4'b0;
      slot_vld_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      wptr_q   <= wptr_n;
      drop_q   <= drop_n;
      status_q <= (status_q & ~flag_w1c) | flag_set;
      irq_q    <= |(status_q & ie_q);
      if (ctrl_wr) begin
        ie_q   <= sample_store_csr_writedata[3:0];
        mode_q <= sample_store_csr_writedata[8];
      end
      if (clear_now) begin
        slot_vld_q <= '0;
      end else if (we) begin
        slot_vld_q[wptr_q] <= 1'b1;
      end
    end
  end

  // Sample RAM: single write port, registered read port, read-before-write
  always_ff @(posedge clock_clk) begin
    if (we && !rst) begin
      mem[wptr_q] <= {response_channel, response_data};
    end
    if (sample_store_csr_read && is_slot) begin
      ram_rd_p1 <= mem[rd_idx];
    end
  end

  // Stage p1: registered read response, held until the next read strobe
  always_ff @(posedge clock_clk) begin
    if (rst) begin
      rd_slot_p1 <= 1'b0;
      rd_vld_p1  <= 1'b0;
      rd_reg_p1  <= '0;
    end else if (sample_store_csr_read) begin
      rd_slot_p1 <= is_slot;
      rd_vld_p1  <= slot_vld_q[rd_idx];
      rd_reg_p1  <= is_ctrl ? ctrl_word : (is_stat ? stat_word : 32'b0);
    end
  end

  assign sample_store_csr_readdata = rd_slot_p1
    ? {rd_vld_p1, 7'b0, 8'(ram_rd_p1[WW-1:DATA_W]), 16'(ram_rd_p1[DATA_W-1:0])}
    : rd_reg_p1;
  assign sample_store_irq_irq = irq_q;

endmodule

// File: tb/tb_adc_sample_store_mc.sv
// Scoreboard bench for adc_sample_store_mc: CSR read expectations are queued at the
// read strobe and compared by a monitor when readdata becomes valid.
module tb_adc_sample_store_mc;

  localparam int NUM_SLOTS = 64;
  localparam int DATA_W    = 12;
  localparam int CH_W      = 5;
  localparam int AW        = $clog2(NUM_SLOTS) + 1;
  localparam int CTRL      = NUM_SLOTS;
  localparam int STAT      = NUM_SLOTS + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid = 1'b0;
  logic [CH_W-1:0]   ch = '0;
  logic [DATA_W-1:0] data = '0;
  logic              eop = 1'b0;
  logic [AW-1:0]     addr = '0;
  logic              rd = 1'b0;
  logic              wr = 1'b0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic              irq;

  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mask_q[$];
  string       name_q[$];
  logic        rd_pend = 1'b0;

  adc_sample_store_mc #(.NUM_SLOTS(NUM_SLOTS), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
    .clock_clk                  (clk),
    .reset_sink_reset           (rst),
    .response_valid             (valid),
    .response_channel           (ch),
    .response_data              (data),
    .response_endofpacket       (eop),
    .sample_store_csr_address   (addr),
    .sample_store_csr_read      (rd),
    .sample_store_csr_write     (wr),
    .sample_store_csr_writedata (wdata),
    .sample_store_csr_readdata  (rdata),
    .sample_store_irq_irq       (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_pend <= rd;

  // Read monitor: pops the scoreboard when the registered read response is valid.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: readdata=%h with no expectation queued", rdata);
      end else begin
        logic [31:0] e, m;
        string nm;
        e  = exp_q.pop_front();
        m  = mask_q.pop_front();
        nm = name_q.pop_front();
        n_vec++;
        if ((rdata & m) !== (e & m)) begin
          n_fail++;
          $display("FAIL %s: readdata=%h expected=%h (mask %h)", nm, rdata, e, m);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input int a, input logic [31:0] d);
    addr = AW'(a); wdata = d; wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  task automatic csr_rd(input int a, input logic [31:0] e, input logic [31:0] m, input string nm);
    exp_q.push_back(e);
    mask_q.push_back(m);
    name_q.push_back(nm);
    addr = AW'(a); rd = 1'b1;
    cyc();
    rd = 1'b0;
  endtask

  task automatic sample(input int c, input int d, input logic e);
    valid = 1'b1; ch = CH_W'(c); data = DATA_W'(d); eop = e;
    cyc();
    valid = 1'b0; eop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    n_vec++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: irq=%b expected=0", irq); end
    n_vec++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: readdata=%h expected=0", rdata); end
    rst = 1'b0;
    cyc();
    csr_rd(CTRL, 32'h0, 32'hFFFF_FFFF, "reset_ctrl");
    csr_rd(STAT, 32'h0, 32'hFFFF_FFFF, "reset_status");
  endtask

  task automatic test_seq_eop();
    for (int i = 0; i < 4; i++) sample(i, 'h100 + i, i == 3);
    csr_rd(STAT, 32'h0000_0001, 32'hFFFF_FFFF, "seq_eop_status");
    csr_rd(2, 32'h8002_0102, 32'hFFFF_FFFF, "seq_slot2");
    csr_rd(3, 32'h8003_0103, 32'hFFFF_FFFF, "seq_slot3");
  endtask

  task automatic test_irq();
    csr_wr(STAT, 32'hF);
    csr_wr(CTRL, 32'h1);
    sample(0, 5, 1'b1);
    n_vec++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: irq=%b expected=0", irq); end
    cyc();
    n_vec++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: irq=%b expected=1", irq); end
    csr_wr(STAT, 32'h1);
    cyc();
    n_vec++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: irq=%b expected=0", irq); end
    // W1C of EOP in the same cycle as a new eop sample
    addr = AW'(STAT); wdata = 32'h1; wr = 1'b1;
    valid = 1'b1; ch = '0; data = DATA_W'(6); eop = 1'b1;
    cyc();
    wr = 1'b0; valid = 1'b0; eop = 1'b0;
    csr_rd(STAT, 32'h0000_0001, 32'hFFFF_FFFF, "set_beats_w1c");
    n_vec++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_setwin: irq=%b expected=1", irq); end
    csr_wr(CTRL, 32'h0);
    csr_wr(STAT, 32'hF);
  endtask

  task automatic test_ring();
    csr_wr(CTRL, 32'h300);
    csr_wr(STAT, 32'hF);
    for (int i = 0; i < 31; i++) sample(i % 32, i, 1'b0);
    csr_rd(STAT, 32'h001F_0000, 32'hFFFF_FFFF, "ring_before_half");
    sample(31, 31, 1'b0);
    csr_rd(STAT, 32'h0020_0002, 32'hFFFF_FFFF, "ring_half");
    for (int i = 32; i < 64; i++) sample(i % 32, i, 1'b0);
    csr_rd(STAT, 32'h0000_0006, 32'hFFFF_FFFF, "ring_full");
    for (int i = 64; i < 128; i++) sample(i % 32, i, 1'b0);
    csr_rd(STAT, 32'h0000_000E, 32'hFFFF_FFFF, "ring_ovf");
    csr_rd(5, 32'h8005_0045, 32'hFFFF_FFFF, "ring_slot5");
    sample(0, 0, 1'b1);
    csr_rd(STAT, 32'h0001_000F, 32'hFFFF_FFFF, "ring_eop_keeps_wptr");
  endtask

  task automatic test_seq_full();
    csr_wr(CTRL, 32'h200);
    csr_wr(STAT, 32'hF);
    for (int i = 0; i < 70; i++) sample(i % 32, 'h200 + i, 1'b0);
    csr_rd(STAT, 32'h0000_0004, 32'h0000_FFFF, "seq_full_flag");
    csr_rd(63, 32'h801F_023F, 32'hFFFF_FFFF, "seq_full_slot63");
    csr_rd(0, 32'h8000_0200, 32'hFFFF_FFFF, "seq_full_slot0");
    sample(9, 'h3FF, 1'b1);
    csr_rd(STAT, 32'h0000_0005, 32'hFFFF_FFFF, "seq_full_eop");
    csr_rd(63, 32'h801F_023F, 32'hFFFF_FFFF, "seq_full_slot63_kept");
    sample(1, 7, 1'b0);
    csr_rd(0, 32'h8001_0007, 32'hFFFF_FFFF, "seq_after_eop_slot0");
  endtask

  task automatic test_clear();
    addr = AW'(CTRL); wdata = 32'h200; wr = 1'b1;
    valid = 1'b1; ch = CH_W'(3); data = DATA_W'('h55); eop = 1'b0;
    cyc();
    wr = 1'b0; valid = 1'b0;
    csr_rd(STAT, 32'h0000_0005, 32'hFFFF_FFFF, "clear_status");
    for (int s = 0; s < NUM_SLOTS; s++) csr_rd(s, 32'h0, 32'h8000_0000, "clear_slot_valid");
    csr_rd(NUM_SLOTS + 5, 32'h0, 32'hFFFF_FFFF, "unmapped_read");
    csr_wr(NUM_SLOTS + 6, 32'hFFFF_FFFF);
    csr_rd(CTRL, 32'h0, 32'hFFFF_FFFF, "unmapped_write_ignored");
    // Same-slot read and capture in one cycle returns the old word
    exp_q.push_back(32'h0001_0007); mask_q.push_back(32'hFFFF_FFFF); name_q.push_back("read_before_write");
    addr = AW'(0); rd = 1'b1;
    valid = 1'b1; ch = CH_W'(2); data = DATA_W'(9);
    cyc();
    rd = 1'b0; valid = 1'b0;
    csr_rd(0, 32'h8002_0009, 32'hFFFF_FFFF, "after_rbw_slot0");
  endtask

  task automatic test_reset_mid();
    csr_wr(STAT, 32'hF);
    csr_wr(CTRL, 32'h10F);
    for (int i = 0; i < 40; i++) sample(i % 32, i, 1'b0);
    cyc();
    n_vec++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL mid_irq_set: irq=%b expected=1", irq); end
    csr_rd(CTRL, 32'h0000_010F, 32'hFFFF_FFFF, "mid_ctrl");
    rst = 1'b1; valid = 1'b1; ch = CH_W'(4); data = DATA_W'(4);
    cyc();
    valid = 1'b0;
    n_vec++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq: irq=%b expected=0", irq); end
    n_vec++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rdata: readdata=%h expected=0", rdata); end
    rst = 1'b0;
    cyc();
    csr_rd(CTRL, 32'h0, 32'hFFFF_FFFF, "mid_reset_ctrl");
    csr_rd(STAT, 32'h0, 32'hFFFF_FFFF, "mid_reset_status");
    csr_rd(1, 32'h0, 32'h8000_0000, "mid_reset_slot_valid");
  endtask

  initial begin
    cyc();
    test_reset();
    test_seq_eop();
    test_irq();
    test_ring();
    test_seq_full();
    test_clear();
    test_reset_mid();
    cyc(); cyc();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
